// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix job loader and its conf decoder.
// Latency: none, declarations only.
// Backpressure: not applicable.
package matrix_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_KICK,
        ST_WAIT,
        ST_RD_ISSUE,
        ST_RD_HOLD
    } state_t;

    // Conf word field positions
    localparam int M_HI = 31;
    localparam int M_LO = 22;
    localparam int K_HI = 21;
    localparam int K_LO = 12;
    localparam int P_HI = 11;
    localparam int P_LO = 2;

    // Fixed RAM layout below the matrix area
    localparam int CONF_ADDR   = 0;
    localparam int STATUS_ADDR = 1;
    localparam int A_BASE      = 2;

    // Status word that tells the multiplier to start
    localparam logic [31:0] START_WORD = 32'h8000_0000;

endpackage

// File: rtl/job_conf_decode.sv
// Extracts m/k/p from a conf word, checks each is in 1..2**N, forms m*k, k*p, m*p.
// Latency: purely combinational.
// Backpressure: none; results follow the input word.
module job_conf_decode import matrix_pkg::*; #(
    parameter int N = 5
) (
    input  logic [31:0]  conf_dat,
    output logic         conf_vld,
    output logic [2*N:0] mk,
    output logic [2*N:0] kp,
    output logic [2*N:0] mp
);
    localparam int FW = M_HI - M_LO + 1;
    localparam int CW = 2*N + 1;
    localparam logic [FW-1:0] DIM_MAX = FW'(2**N);

    logic [FW-1:0] m_raw;
    logic [FW-1:0] k_raw;
    logic [FW-1:0] p_raw;
    logic [CW-1:0] m_w;
    logic [CW-1:0] k_w;
    logic [CW-1:0] p_w;
    logic          unused_conf_bits;

    // The two low bits of the conf word carry no field
    assign unused_conf_bits = ^conf_dat[P_LO-1:0];

    // Field extraction, range check and dimension products
    always_comb begin
        m_raw    = conf_dat[M_HI:M_LO];
        k_raw    = conf_dat[K_HI:K_LO];
        p_raw    = conf_dat[P_HI:P_LO];
        conf_vld = (m_raw != '0) && (m_raw <= DIM_MAX) &&
                   (k_raw != '0) && (k_raw <= DIM_MAX) &&
                   (p_raw != '0) && (p_raw <= DIM_MAX);
        // Products only matter for a valid conf, where each factor is <= 2**N
        // and the product fits in 2N+1 bits.
        m_w = CW'(m_raw);
        k_w = CW'(k_raw);
        p_w = CW'(p_raw);
        mk  = m_w * k_w;
        kp  = k_w * p_w;
        mp  = m_w * p_w;
    end

endmodule

// File: rtl/matrix_job_loader.sv
// Loads conf/A/B into the shared job RAM, starts the multiplier, streams the result back.
// Latency: RAM write one cycle after each input handshake; result word two cycles per word minimum.
// Backpressure: in_ready drops outside IDLE/LOAD; out_valid/out_data hold until out_ready. Option: LOADER_TIMEOUT_EN.
module matrix_job_loader import matrix_pkg::*; #(
    parameter int N        = 5,
    parameter int S        = 2*N + 2,
    parameter int RES_BASE = 3 * 2**(2*N)
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic [S-1:0] ram_addr,
    output logic [31:0]  ram_wdata,
    output logic         ram_we,
    input  logic [31:0]  ram_rdata,
    output logic         bus_own,
    input  logic         mm_done,
    output logic         busy,
    output logic         err
);
    localparam int CW = 2*N + 1;
`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] ridx_q, ridx_d;
    logic [31:0]   conf_q, conf_d;
    logic [S-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]   wr_dat_q, wr_dat_d;
    logic          wr_vld_q, wr_vld_d;
    logic          bus_own_q, bus_own_d;
    logic          err_q, err_d;
    logic [31:0]   out_dat_q, out_dat_d;
    logic          hold_q, hold_d;
`ifdef LOADER_TIMEOUT_EN
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          wait_expired;
`endif

    logic [31:0]   dec_dat;
    logic          conf_vld;
    logic [CW-1:0] mk, kp, mp;
    logic          in_hs;
    logic          a_last, b_done, r_last;
    logic [S-1:0]  rd_addr;

    // In IDLE the incoming word is the candidate conf; afterwards the stored one rules.
    assign dec_dat = (state_q == ST_IDLE) ? in_data : conf_q;

    job_conf_decode #(.N(N)) u_dec (
        .conf_dat (dec_dat),
        .conf_vld (conf_vld),
        .mk       (mk),
        .kp       (kp),
        .mp       (mp)
    );

    assign in_hs   = in_valid & in_ready;
    assign a_last  = (idx_q == mk - CW'(1));
    assign b_done  = (idx_q == kp);
    assign r_last  = (ridx_q == mp - CW'(1));
    assign rd_addr = S'(RES_BASE) + S'(ridx_q);
`ifdef LOADER_TIMEOUT_EN
    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; bus_own resets to 1 so the loader owns the RAM after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            ridx_q     <= '0;
            conf_q     <= '0;
            wr_addr_q  <= '0;
            wr_dat_q   <= '0;
            wr_vld_q   <= 1'b0;
            bus_own_q  <= 1'b1;
            err_q      <= 1'b0;
            out_dat_q  <= '0;
            hold_q     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            idx_q      <= idx_d;
            ridx_q     <= ridx_d;
            conf_q     <= conf_d;
            wr_addr_q  <= wr_addr_d;
            wr_dat_q   <= wr_dat_d;
            wr_vld_q   <= wr_vld_d;
            bus_own_q  <= bus_own_d;
            err_q      <= err_d;
            out_dat_q  <= out_dat_d;
            hold_q     <= hold_d;
`ifdef LOADER_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (in_hs && conf_vld) state_d = ST_LOAD_A;
            ST_LOAD_A:   if (in_hs && a_last) state_d = ST_LOAD_B;
            // Leave only once the last B write has been presented, so the
            // start write gets the port to itself in KICK.
            ST_LOAD_B:   if (b_done) state_d = ST_KICK;
            ST_KICK:     state_d = ST_WAIT;
            ST_WAIT: begin
                if (mm_done) begin
                    state_d = ST_RD_ISSUE;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_RD_ISSUE: state_d = ST_RD_HOLD;
            ST_RD_HOLD:  if (out_ready) state_d = r_last ? ST_IDLE : ST_RD_ISSUE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Per-state register updates and port outputs
    always_comb begin
        idx_d     = idx_q;
        ridx_d    = ridx_q;
        conf_d    = conf_q;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        wr_vld_d  = 1'b0;
        bus_own_d = bus_own_q;
        err_d     = err_q;
        out_dat_d = out_dat_q;
        hold_d    = hold_q;
`ifdef LOADER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE, ST_LOAD_A: in_ready = rst;
            ST_LOAD_B:          in_ready = rst && (idx_q < kp);
            default:            in_ready = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    if (conf_vld) begin
                        conf_d    = in_data;
                        err_d     = 1'b0;
                        wr_addr_d = S'(CONF_ADDR);
                        wr_dat_d  = in_data;
                        wr_vld_d  = 1'b1;
                        idx_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_A: begin
                if (in_hs) begin
                    wr_addr_d = S'(A_BASE) + S'(idx_q);
                    wr_dat_d  = in_data;
                    wr_vld_d  = 1'b1;
                    idx_d     = a_last ? '0 : idx_q + CW'(1);
                end
            end
            ST_LOAD_B: begin
                if (in_hs) begin
                    wr_addr_d = S'(A_BASE) + S'(mk) + S'(idx_q);
                    wr_dat_d  = in_data;
                    wr_vld_d  = 1'b1;
                    idx_d     = idx_q + CW'(1);
                end else if (b_done) begin
                    wr_addr_d = S'(STATUS_ADDR);
                    wr_dat_d  = START_WORD;
                    wr_vld_d  = 1'b1;
                end
            end
            ST_KICK: begin
                // Start write is on the port this cycle; hand over from the next one.
                bus_own_d = 1'b0;
`ifdef LOADER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (mm_done) begin
                    bus_own_d = 1'b1;
                    ridx_d    = '0;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (wait_expired) begin
                    err_d     = 1'b1;
                    bus_own_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            ST_RD_ISSUE: hold_d = 1'b0;
            ST_RD_HOLD: begin
                // First hold cycle shows RAM data directly; keep a copy for any stall.
                if (!hold_q) begin
                    out_dat_d = ram_rdata;
                    hold_d    = 1'b1;
                end
                if (out_ready) begin
                    hold_d = 1'b0;
                    ridx_d = ridx_q + CW'(1);
                end
            end
            default: ;
        endcase

        // Keep the read address on the port through the hold so nothing else is read.
        ram_addr  = (state_q == ST_RD_ISSUE || state_q == ST_RD_HOLD) ? rd_addr : wr_addr_q;
        ram_wdata = wr_dat_q;
        ram_we    = wr_vld_q;
        out_valid = (state_q == ST_RD_HOLD);
        out_data  = hold_q ? out_dat_q : ram_rdata;
        out_last  = (state_q == ST_RD_HOLD) && r_last;
        bus_own   = bus_own_q;
        busy      = (state_q != ST_IDLE);
        err       = err_q;
    end

endmodule

// File: tb/tb_matrix_job_loader.sv
// Scoreboard bench for matrix_job_loader: RAM writes and result words checked in order.
// Latency: not applicable.
// Backpressure: out_ready stalled on demand; in_valid gaps randomised.
module tb_matrix_job_loader;
    localparam int N        = 5;
    localparam int S        = 12;
    localparam int RES_BASE = 3072;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [S-1:0] ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_we;
    logic [31:0]  ram_rdata;
    logic         bus_own;
    logic         mm_done;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    matrix_job_loader #(
        .N(N)
`ifdef LOADER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .bus_own(bus_own), .mm_done(mm_done), .busy(busy), .err(err)
    );

    // RAM model: loader writes go to mem; the multiplier's results live in res_mem.
    logic [31:0] mem [0:4095];
    logic [31:0] res_mem [0:1023];
    always @(posedge clk) begin
        if (ram_we && bus_own) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr >= 12'(RES_BASE)) ? res_mem[ram_addr - 12'(RES_BASE)] : mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [43:0] wq[$];   // {addr, data} of expected RAM writes
    logic [32:0] rq[$];   // {last, data} of expected result words
    logic [43:0] mon_w;
    logic [32:0] mon_r;

    // Monitor: every RAM write and every accepted result word is matched in order.
    always @(negedge clk) begin
        if (rst && ram_we) begin
            if (wq.size() == 0) begin
                chk("wr_extra", 64'(ram_we), 64'd0);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_addr", 64'(ram_addr), 64'(mon_w[43:32]));
                chk("wr_data", 64'(ram_wdata), 64'(mon_w[31:0]));
                chk("wr_own", 64'(bus_own), 64'd1);
            end
        end
        if (rst && out_valid && out_ready) begin
            if (rq.size() == 0) begin
                chk("out_extra", 64'(out_valid), 64'd0);
            end else begin
                mon_r = rq.pop_front();
                chk("out_data", 64'(out_data), 64'(mon_r[31:0]));
                chk("out_last", 64'(out_last), 64'(mon_r[32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, optionally after random idle cycles, and wait for acceptance.
    task automatic send(input logic [31:0] w, input int gap_pct, input logic exp_we);
        logic hs;
        int   g;
        if (gap_pct > 0) begin
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(99) >= gap_pct) break;
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        hs = 1'b0;
        g  = 0;
        while (!hs && g < 50) begin
            hs = in_ready;
            tick();
            g++;
        end
        in_valid = 1'b0;
        chk("in_hs", 64'(hs), 64'd1);
        chk("wr_lat", 64'(ram_we), 64'(exp_we));
    endtask

    // Accept n result words; optionally stall word stall_at for 5 cycles.
    task automatic drain(input int n, input int stall_at);
        int          got;
        int          g;
        logic        stalled;
        logic [31:0] d0;
        logic [S-1:0] a0;
        got = 0;
        g = 0;
        stalled = 1'b0;
        out_ready = 1'b1;
        while (got < n && g < 400) begin
            if (out_valid) begin
                if (got == stall_at && !stalled) begin
                    out_ready = 1'b0;
                    d0 = out_data;
                    a0 = ram_addr;
                    repeat (5) begin
                        tick();
                        chk("stall_dat", 64'(out_data), 64'(d0));
                        chk("stall_addr", 64'(ram_addr), 64'(a0));
                        chk("stall_vld", 64'(out_valid), 64'd1);
                    end
                    stalled = 1'b1;
                    out_ready = 1'b1;
                end
                got++;
            end
            tick();
            g++;
        end
        chk("drain_cnt", 64'(got), 64'(n));
        out_ready = 1'b1;
    endtask

    // Full job: load, start, optionally complete and collect results.
    task automatic run_job(input int m, input int k, input int p, input int a_base, input int b_base,
                           input int gap, input int stall_at, input logic do_done);
        logic [31:0] conf;
        logic [31:0] a [0:63];
        logic [31:0] b [0:63];
        logic [31:0] s;
        int g;
        conf = (32'(m) << 22) | (32'(k) << 12) | (32'(p) << 2);
        wq.push_back({12'd0, conf});
        send(conf, gap, 1'b1);
        chk("err_clr", 64'(err), 64'd0);
        chk("busy_load", 64'(busy), 64'd1);
        for (int i = 0; i < m*k; i++) begin
            a[i] = 32'(a_base + i);
            wq.push_back({12'(2 + i), a[i]});
            send(a[i], gap, 1'b1);
        end
        for (int i = 0; i < k*p; i++) begin
            b[i] = 32'(b_base + i);
            wq.push_back({12'(2 + m*k + i), b[i]});
            send(b[i], gap, 1'b1);
        end
        wq.push_back({12'd1, 32'h8000_0000});
        g = 0;
        while (bus_own && g < 20) begin
            tick();
            g++;
        end
        chk("own_fall", 64'(bus_own), 64'd0);
        chk("wr_drained", 64'(wq.size()), 64'd0);
        chk("in_rdy_wait", 64'(in_ready), 64'd0);
        if (do_done) begin
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < p; c++) begin
                    s = '0;
                    for (int x = 0; x < k; x++) s = s + a[r*k + x] * b[x*p + c];
                    res_mem[r*p + c] = s;
                    rq.push_back({(r*p + c == m*p - 1), s});
                end
            end
            repeat (3) tick();
            mm_done = 1'b1;
            tick();
            mm_done = 1'b0;
            chk("own_back", 64'(bus_own), 64'd1);
            drain(m*p, stall_at);
            tick();
            chk("idle_after", 64'(busy), 64'd0);
            chk("rq_empty", 64'(rq.size()), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        mm_done   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_own", 64'(bus_own), 64'd1);
        chk("rst_in_rdy", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_vld", 64'(out_valid), 64'd0);
        rst = 1'b1;
        tick();

        // Stray completion pulse in IDLE is ignored
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        tick();
        chk("stray_done", 64'(busy), 64'd0);
        chk("in_rdy_idle", 64'(in_ready), 64'd1);

        // 2x2x2: results 19,22,43,50
        run_job(2, 2, 2, 1, 5, 0, -1, 1'b1);

        // All-zero conf is rejected
        send(32'h0000_0000, 0, 1'b0);
        chk("err_set", 64'(err), 64'd1);
        chk("in_rdy_err", 64'(in_ready), 64'd1);
        chk("busy_err", 64'(busy), 64'd0);

        // 3x1x2 clears err; stall on result word 2
        run_job(3, 1, 2, 10, 20, 0, 2, 1'b1);
        // Same job with ~50% input gaps
        run_job(3, 1, 2, 10, 20, 50, -1, 1'b1);

        // m one above the limit is rejected
        send((32'd33 << 22) | (32'd1 << 12) | (32'd1 << 2), 0, 1'b0);
        chk("err_m33", 64'(err), 64'd1);

        // Largest dimension and smallest job
        run_job(32, 1, 1, 3, 7, 0, -1, 1'b1);
        run_job(1, 1, 1, 7, 9, 0, 0, 1'b1);

        // Reset in the middle of LOAD_A
        wq.push_back({12'd0, 32'h0080_2008});
        send(32'h0080_2008, 0, 1'b1);
        wq.push_back({12'd2, 32'd1});
        send(32'd1, 0, 1'b1);
        wq.push_back({12'd3, 32'd2});
        send(32'd2, 0, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_own", 64'(bus_own), 64'd1);
        chk("mid_rst_we", 64'(ram_we), 64'd0);
        chk("mid_rst_in_rdy", 64'(in_ready), 64'd0);
        tick();
        tick();
        wq.delete();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 64'(busy), 64'd0);
        run_job(2, 2, 2, 1, 5, 0, -1, 1'b1);

`ifdef LOADER_TIMEOUT_EN
        // No completion: watchdog fires at WAIT cycle 64
        run_job(2, 2, 2, 1, 5, 0, -1, 1'b0);
        repeat (63) tick();
        chk("to_early", 64'(err), 64'd0);
        tick();
        chk("to_err", 64'(err), 64'd1);
        chk("to_own", 64'(bus_own), 64'd1);
        chk("to_idle", 64'(busy), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_job_loader.md
Name: matrix_job_loader

Overview:
- Host-side stage directly upstream of the matrix multiplier controller; both share one single-port 32-bit job RAM.
- Accepts a job as a 32-bit word stream, then writes the configuration, matrix A and matrix B into RAM and sets the start bit in the status word.
- Hands the RAM port to the multiplier, waits for completion, takes the port back and streams the result matrix out.

Parameters:
- N, 5, log2 of the maximum matrix dimension.
- S, 2*N+2, RAM address width.
- RES_BASE, 3*2**(2*N), RAM address of result element [0][0].
- TIMEOUT_CYCLES, 2**20, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  job word valid.
- in_ready  out  1  job word accepted when in_valid and in_ready are both high.
- in_data  in  32  job word: conf first, then A row-major, then B row-major.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_data  out  32  result word, row-major.
- out_last  out  1  high with the final result word.
- ram_addr  out  S  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  32  RAM read data; synchronous read, valid one cycle after the address.
- bus_own  out  1  1 = this block drives the RAM port; 0 = the multiplier drives it (external mux select).
- mm_done  in  1  single-cycle completion pulse from the multiplier.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: all registered outputs 0, except bus_own=1. State = IDLE. in_ready is forced to 0 while rst is low.
- Conf word layout:
  - m = conf[31:22], rows of A.
  - k = conf[21:12], columns of A and rows of B.
  - p = conf[11:2], columns of B.
- Conf is valid when m, k and p are each in 1..2**N.
- IDLE:
  - in_ready=1.
  - On handshake with a valid conf: write conf to addr 0, clear err, go to LOAD_A.
  - On handshake with an invalid conf: set err, no RAM write, stay in IDLE.
- LOAD_A:
  - in_ready=1.
  - Each handshake writes the word to addr 2+idx, idx = 0 .. m*k-1.
  - After the last word, go to LOAD_B.
- LOAD_B:
  - Each handshake writes the word to addr 2+m*k+idx, idx = 0 .. k*p-1.
  - Then go to KICK.
- Write timing: each write is presented on the cycle after the handshake (ram_we=1 for exactly one cycle). Gaps in in_valid stall without penalty.
- KICK:
  - One cycle: write 0x8000_0000 to addr 1.
  - Next cycle: bus_own=0, go to WAIT.
- WAIT:
  - bus_own=0, ram_we=0.
  - On mm_done: bus_own=1, go to RD_ISSUE.
- RD_ISSUE: ram_addr = RES_BASE+ridx, ridx = 0 .. m*p-1; go to RD_HOLD.
- RD_HOLD:
  - Capture ram_rdata into out_data and assert out_valid.
  - Hold out_data and out_valid stable until out_ready is high.
  - out_last=1 when ridx = m*p-1.
  - On acceptance: next ridx to RD_ISSUE, or to IDLE after the last word.
  - Throughput is one word per two cycles minimum.
- Index counters are 2N+1 bits wide. Address sums are truncated to S bits.
- in_ready=0 in KICK, WAIT, RD_ISSUE and RD_HOLD.
- A mm_done pulse outside WAIT is ignored.
- 1x1x1 job: A and B are one word each; a single result word is returned with out_last=1.
- Asynchronous reset mid-job: immediate return to IDLE with bus_own=1. Partially written RAM is left as is; no cleanup.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES without mm_done: set err, bus_own=1, go to IDLE, no result stream.
  - The counter clears on every entry to WAIT.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Shared package matrix_pkg:
  - state enum.
  - conf field bit positions (M_HI/M_LO, K_HI/K_LO, P_HI/P_LO).
  - CONF_ADDR=0, STATUS_ADDR=1, A_BASE=2.
  - START_WORD=32'h8000_0000.
- Sub-module job_conf_decode: combinational field extraction, validity check, and the m*k, k*p, m*p products.

Test Plan:
- 2x2x2 job, conf 0x0080_2008, A={1,2,3,4}, B={5,6,7,8}:
  - Writes to addr 0, 2..5, 6..9, then 0x8000_0000 to addr 1; bus_own falls.
  - Pulse mm_done with RAM 3072..3075 = {19,22,43,50}: those four words stream out, out_last on 50.
- Conf 0x0000_0000: err=1, no ram_we, in_ready stays 1. A following valid conf clears err.
- 3x1x2 job, conf 0x00C0_1008:
  - A goes to 2..4, B to 5..6.
  - Six result reads from 3072..3077.
  - Hold out_ready low 5 cycles on word 2: out_data stable, no extra reads.
- Random in_valid gaps (50% duty) during load: identical RAM contents and order as with gap-free input.
- Reset pulse mid-LOAD_A: state IDLE, bus_own=1, ram_we=0 during reset. A fresh 2x2x2 job then completes correctly.
- With LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=64 and no mm_done: err=1 and bus_own=1 at cycle 64 of WAIT, return to IDLE.
